// File: rtl/idma_inoc_wr_ibuffer.sv
// idma_inoc_wr_ibuffer: packs a 32-bit word stream into strobed ibuffer SRAM line writes
`timescale 1ns/1ps
module idma_inoc_wr_ibuffer #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int WORD_WIDTH = 32,
  parameter int WORD_NUM   = DATA_WIDTH/WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ibuffer_wr_start,
  input  logic [MEM_AW+1:0]     ibuffer_word_addr,
  input  logic [12:0]           ibuffer_word_num,
  input  logic                  op_last_or_finish,
  input  logic                  recv_valid,
  output logic                  recv_ready,
  input  logic [WORD_WIDTH-1:0] recv_data,
  input  logic                  recv_last,
  output logic                  ibuffer_cen,
  output logic                  ibuffer_wen,
  input  logic                  ibuffer_ready,
  output logic [MEM_AW-1:0]     ibuffer_addr,
  output logic [DATA_WIDTH-1:0] ibuffer_wdata,
  output logic [STRB_WIDTH-1:0] ibuffer_wstrb,
  output logic                  wr_busy,
  output logic                  wr_done,
  output logic                  len_err
);
  logic                  fin, zdone, acc, last_w, done_line, hs, start;
  logic [12:0]           num_q, cnt;
  logic [1:0]            off;
  logic [MEM_AW-1:0]     line;
  logic [DATA_WIDTH-1:0] pack, pack_n;
  logic [STRB_WIDTH-1:0] strb, strb_n;
  assign ibuffer_wen = 1'b1;
  assign hs          = ibuffer_cen && ibuffer_ready;
  assign recv_ready  = wr_busy && (!ibuffer_cen || ibuffer_ready) && !op_last_or_finish;
  assign acc         = recv_valid && recv_ready;
  assign last_w      = cnt == num_q - 13'd1;
  assign done_line   = acc && (off == 2'(WORD_NUM-1) || last_w);
  assign start       = ibuffer_wr_start && !wr_busy;
  assign wr_done     = (hs && fin && !op_last_or_finish) || zdone;
  always_comb begin
    pack_n = pack;
    strb_n = strb;
    pack_n[off*WORD_WIDTH +: WORD_WIDTH] = recv_data;
    strb_n[off*(WORD_WIDTH/8) +: WORD_WIDTH/8] = '1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_busy       <= 1'b0;
      ibuffer_cen   <= 1'b0;
      ibuffer_addr  <= '0;
      ibuffer_wdata <= '0;
      ibuffer_wstrb <= '0;
      len_err       <= 1'b0;
      fin           <= 1'b0;
      zdone         <= 1'b0;
      num_q         <= '0;
      cnt           <= '0;
      off           <= '0;
      line          <= '0;
      pack          <= '0;
      strb          <= '0;
    end else if (op_last_or_finish) begin
      wr_busy     <= 1'b0;
      ibuffer_cen <= 1'b0;
      fin         <= 1'b0;
      zdone       <= 1'b0;
      cnt         <= '0;
      off         <= '0;
      pack        <= '0;
      strb        <= '0;
    end else begin
      zdone <= start && ibuffer_word_num == '0;
      if (start && ibuffer_word_num != '0) begin
        wr_busy <= 1'b1;
        num_q   <= ibuffer_word_num;
        off     <= ibuffer_word_addr[1:0];
        line    <= ibuffer_word_addr[MEM_AW+1:2];
        cnt     <= '0;
        pack    <= '0;
        strb    <= '0;
        len_err <= 1'b0;
      end
      if (acc) begin
        cnt  <= cnt + 13'd1;
        off  <= off + 2'd1;
        pack <= pack_n;
        strb <= strb_n;
        if (recv_last != last_w) len_err <= 1'b1;
        if (last_w) wr_busy <= 1'b0;
      end
      if (done_line) begin
        ibuffer_cen   <= 1'b1;
        fin           <= last_w;
        ibuffer_addr  <= line;
        ibuffer_wdata <= pack_n;
        ibuffer_wstrb <= strb_n;
        pack          <= '0;
        strb          <= '0;
        line          <= line + MEM_AW'(1);
      end else if (hs) ibuffer_cen <= 1'b0;
    end
  end
endmodule

// File: doc/idma_inoc_wr_ibuffer.md
# idma_inoc_wr_ibuffer

Write-side counterpart of the iNoC ibuffer read path. Accepts a stream of 32-bit words from the iNoC receive side, packs them into DATA_WIDTH-bit lines starting at an arbitrary word address, and writes each line to the ibuffer SRAM with byte strobes. Partial first and last lines are written with strobes masked. Sits between the iDMA iNoC receive channel and the ibuffer SRAM write port.

## Interface
Parameters:
- DATA_WIDTH, 128, ibuffer line width
- MEM_AW, 15, ibuffer line address width
- STRB_WIDTH, DATA_WIDTH/8, byte strobes per line
- WORD_WIDTH, 32, stream word width
- WORD_NUM, DATA_WIDTH/WORD_WIDTH (4), words per line

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ibuffer_wr_start  in  1  start pulse; sampled only when wr_busy=0
- ibuffer_word_addr  in  MEM_AW+2  start word address; [1:0] is word offset, [MEM_AW+1:2] is line address
- ibuffer_word_num  in  13  word count, 1..8191
- op_last_or_finish  in  1  abort; highest priority
- recv_valid  in  1  stream word valid
- recv_ready  out  1  stream word ready
- recv_data  in  WORD_WIDTH  stream word
- recv_last  in  1  sender's last-word marker; checked only
- ibuffer_cen  out  1  SRAM request valid
- ibuffer_wen  out  1  constant 1 (write)
- ibuffer_ready  in  1  SRAM accepts request
- ibuffer_addr  out  MEM_AW  line address
- ibuffer_wdata  out  DATA_WIDTH  line data
- ibuffer_wstrb  out  STRB_WIDTH  byte enables; bit i covers byte i
- wr_busy  out  1  transfer in progress
- wr_done  out  1  one-cycle pulse: final line accepted by SRAM
- len_err  out  1  sticky: recv_last mismatched the word count

## Operation
- Idle (wr_busy=0). On ibuffer_wr_start with word_num≠0: latch word_num, set word_offset=word_addr[1:0], next line addr=word_addr[MEM_AW+1:2], clear word count, pack strobe and len_err; set wr_busy.
- word_num=0 at start: no writes, wr_busy stays 0, wr_done pulses the next cycle.
- recv_ready = wr_busy && (!ibuffer_cen || ibuffer_ready).
- Word accept (recv_valid && recv_ready): data placed at pack bits [offset*32+:32], pack strobe bits [offset*4+:4]=4'hF; offset increments mod 4; word count increments.
- Line complete when the accepted word has offset 3 or is word word_num-1. Same cycle: pack data/strobe load into output register, ibuffer_cen set, ibuffer_addr=current line addr. Pack data and strobe clear; line addr increments, wrapping mod 2^MEM_AW.
- Output register holds (cen, addr, wdata, wstrb) stable while cen && !ready. Cen drops after handshake unless a new line loads in the same cycle.
- Last word accepted: wr_busy clears; recv_ready drops. wr_done pulses in the cycle the final line's ibuffer handshake occurs.
- len_err sets if recv_last=1 on any word other than word word_num-1, or recv_last=0 on word word_num-1. Transfer still completes by count. len_err clears only on next start.
- Abort (op_last_or_finish): same cycle forces recv_ready=0. Next edge: cen=0, wr_busy=0, pack/strobe cleared, counters cleared, no wr_done. A pending un-accepted line is dropped. Abort coincident with start: abort wins.

## Timing
- Reset values: recv_ready 0, ibuffer_cen 0, ibuffer_wen 1, ibuffer_addr 0, ibuffer_wdata 0, ibuffer_wstrb 0, wr_busy 0, wr_done 0, len_err 0.
- Start at edge N: wr_busy=1 and recv_ready may be 1 from cycle N+1.
- Latency: the completing word is accepted at edge M; ibuffer_cen=1 with that line from cycle M+1.
- Throughput: 1 word/cycle sustained with ibuffer_ready=1. A line completing while the previous line is stalled is blocked by recv_ready=0.
- wr_done is combinational on the final handshake cycle (cen && ready && final-line flag), one cycle wide.

## Test plan
- addr=0, num=8, ready=1, words 0..7 back-to-back -> writes to line 0 then line 1, wstrb 16'hFFFF each; wr_done on second handshake; len_err=0 with recv_last on word 7.
- addr=5, num=6 -> line 1 wstrb 16'hFFF0 (words 0-2 in bytes 4-15); line 2 wstrb 16'h0FFF; exactly two writes.
- addr=3, num=1 -> single write to line 0, wstrb 16'hF000, data in [127:96]; wr_done same cycle as handshake.
- num=12, ibuffer_ready held 0 for 5 cycles on line 1 -> addr/wdata/wstrb stable while held; recv_ready=0 while the next line completes; no word lost; 3 writes total.
- Abort after 6 of 12 words -> line 0 written; cen=0 and recv_ready=0 the following cycle; no wr_done; new start then works normally.
- num=4, recv_last on word 2 -> len_err=1; 4 words still accepted; one full write; wr_done pulses.
